// File: rtl/vga_capture_480p.sv
// Receive-side VGA capture: registers sync/colour from a 480p source, locks to its timing,
// and recovers signed pixel coordinates, data enable, line/frame strobes and colour.
module vga_capture_480p #(
  parameter int CORDW    = 16,
  parameter int CHANW    = 4,
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic             vga_hsync,
  input  logic             vga_vsync,
  input  logic [CHANW-1:0] vga_r,
  input  logic [CHANW-1:0] vga_g,
  input  logic [CHANW-1:0] vga_b,
  output logic [CORDW-1:0] cap_sx,
  output logic [CORDW-1:0] cap_sy,
  output logic             cap_de,
  output logic [CHANW-1:0] cap_r,
  output logic [CHANW-1:0] cap_g,
  output logic [CHANW-1:0] cap_b,
  output logic             cap_line,
  output logic             cap_frame,
  output logic             locked,
  output logic             err_h,
  output logic             err_v
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam logic [CORDW-1:0] H_TOT  = CORDW'(H_TOTAL);
  localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_TOT  = CORDW'(V_TOTAL);
  localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_OFS  = CORDW'(H_SYNC + H_BP);
  localparam logic [CORDW-1:0] V_OFS  = CORDW'(V_SYNC + V_BP);
  localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
  localparam logic [CORDW-1:0] H_SW   = CORDW'(H_SYNC);
  localparam logic [CORDW-1:0] V_SW   = CORDW'(V_SYNC);

  typedef enum logic [1:0] {UNLOCKED, HSEEN, MEASURE, LOCKED} state_t;
  state_t state, state_n;

  logic             hs1, vs1, hs1_d;
  logic [CHANW-1:0] r1, g1, b1;
  logic [CORDW-1:0] hcnt, hcnt_n, hs_w, hs_w_n, vcnt, vcnt_n, vs_w, vs_w_n;
  logic             vs_armed, vs_armed_n;
  logic             hs_rise, vclr, eh, ev, h_chk, v_chk;
  logic [CORDW-1:0] sx_n, sy_n;
  logic             lk_n, act_y, de_n;

  // Stage 1: input registers with syncs normalised to active-high
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      hs1 <= 1'b0; vs1 <= 1'b0; hs1_d <= 1'b0;
      r1 <= '0; g1 <= '0; b1 <= '0;
    end else begin
      hs1   <= (SYNC_POL != 0) ? vga_hsync : ~vga_hsync;
      vs1   <= (SYNC_POL != 0) ? vga_vsync : ~vga_vsync;
      hs1_d <= hs1;
      r1 <= vga_r; g1 <= vga_g; b1 <= vga_b;
    end
  end

  always_comb begin
    hs_rise    = hs1 & ~hs1_d;
    vclr       = hs_rise & vs1 & vs_armed;
    hcnt_n     = hs_rise ? '0 : ((hcnt == H_TOT) ? hcnt : hcnt + 1'b1);
    hs_w_n     = hs_rise ? CORDW'(1) : ((hs1 && hs_w != H_TOT) ? hs_w + 1'b1 : hs_w);
    vcnt_n     = vclr ? '0 : ((hs_rise && vcnt != V_TOT) ? vcnt + 1'b1 : vcnt);
    vs_w_n     = vclr ? CORDW'(1) : ((hs_rise && vs1 && vs_w != V_TOT) ? vs_w + 1'b1 : vs_w);
    vs_armed_n = vclr ? 1'b0 : (!vs1 ? 1'b1 : vs_armed);

    // Vertical history is only meaningful once a vsync-aligned clear has been seen
    h_chk = (state != UNLOCKED);
    v_chk = (state == MEASURE) || (state == LOCKED);
    eh = h_chk && ((hs_rise && (hcnt != H_LAST || hs_w != H_SW)) ||
                   (!hs_rise && hcnt == H_LAST));
    ev = v_chk && ((vclr && (vcnt != V_LAST || vs_w != V_SW)) ||
                   (hs_rise && !vclr && vcnt == V_LAST));

    state_n = state;
    case (state)
      UNLOCKED: if (hs_rise) state_n = HSEEN;
      HSEEN:    if (vclr)    state_n = MEASURE;
      MEASURE:  if (vclr)    state_n = LOCKED;
      default:  state_n = state;
    endcase
    if (eh || ev) state_n = UNLOCKED;

    sx_n  = hcnt_n - H_OFS;
    sy_n  = vcnt_n - V_OFS;
    lk_n  = (state_n == LOCKED);
    act_y = !sy_n[CORDW-1] && (sy_n < V_ACT);
    de_n  = lk_n && act_y && !sx_n[CORDW-1] && (sx_n < H_ACT);
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state <= UNLOCKED;
      hcnt <= '0; hs_w <= '0; vcnt <= '0; vs_w <= '0; vs_armed <= 1'b0;
      cap_sx <= '0; cap_sy <= '0; cap_de <= 1'b0;
      cap_r <= '0; cap_g <= '0; cap_b <= '0;
      cap_line <= 1'b0; cap_frame <= 1'b0; err_h <= 1'b0; err_v <= 1'b0;
    end else begin
      state <= state_n;
      hcnt <= hcnt_n; hs_w <= hs_w_n; vcnt <= vcnt_n; vs_w <= vs_w_n; vs_armed <= vs_armed_n;
      cap_sx    <= sx_n;
      cap_sy    <= sy_n;
      cap_de    <= de_n;
      cap_r     <= de_n ? r1 : '0;
      cap_g     <= de_n ? g1 : '0;
      cap_b     <= de_n ? b1 : '0;
      cap_line  <= lk_n && (sx_n == '0) && act_y;
      cap_frame <= lk_n && (sx_n == '0) && (sy_n == '0);
      err_h     <= eh;
      err_v     <= ev;
    end
  end

  // state is itself a register, so locked lines up with the cap_* outputs
  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_capture_480p.sv
// Directed bench for vga_capture_480p on a scaled-down raster, one instance per sync polarity
// fed from the same source; source faults are keyed to fixed frame/line positions.
module tb_vga_capture_480p;
  localparam int HR = 16, HF = 2, HS = 4, HB = 3, HT = HR + HF + HS + HB;
  localparam int VR = 8,  VF = 2, VS = 2, VB = 3, VT = VR + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int HOFS = HF + HS + HB;
  localparam int VOFS = VF + VS + VB;

  logic clk = 1'b0, rst = 1'b1;
  logic hs_p, vs_p, hs_q, vs_q;
  logic [3:0] vr, vg, vb;
  logic [15:0] sx1, sy1, sx2, sy2;
  logic [3:0] r1, g1, b1, r2, g2, b2;
  logic de1, line1, frame1, locked1, eh1, ev1;
  logic de2, line2, frame2, locked2, eh2, ev2;

  int frame = 0, vc = 0, hc = 0, pos1 = -1, pos2 = -1;
  int n_chk = 0, n_err = 0;
  int n_eh1 = 0, n_ev1 = 0, n_eh2 = 0, n_ev2 = 0, n_de1 = 0, de_mark = 0;

  always #5 clk = ~clk;

  vga_capture_480p #(.CORDW(16), .CHANW(4), .H_RES(HR), .V_RES(VR), .H_FP(HF), .H_SYNC(HS),
    .H_BP(HB), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)) dut_lo (
    .clk_pix(clk), .rst_pix(rst), .vga_hsync(hs_p), .vga_vsync(vs_p),
    .vga_r(vr), .vga_g(vg), .vga_b(vb), .cap_sx(sx1), .cap_sy(sy1), .cap_de(de1),
    .cap_r(r1), .cap_g(g1), .cap_b(b1), .cap_line(line1), .cap_frame(frame1),
    .locked(locked1), .err_h(eh1), .err_v(ev1));

  vga_capture_480p #(.CORDW(16), .CHANW(4), .H_RES(HR), .V_RES(VR), .H_FP(HF), .H_SYNC(HS),
    .H_BP(HB), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1)) dut_hi (
    .clk_pix(clk), .rst_pix(rst), .vga_hsync(hs_q), .vga_vsync(vs_q),
    .vga_r(vr), .vga_g(vg), .vga_b(vb), .cap_sx(sx2), .cap_sy(sy2), .cap_de(de2),
    .cap_r(r2), .cap_g(g2), .cap_b(b2), .cap_line(line2), .cap_frame(frame2),
    .locked(locked2), .err_h(eh2), .err_v(ev2));

  always @(negedge clk) begin
    if (eh1) n_eh1 <= n_eh1 + 1;
    if (ev1) n_ev1 <= n_ev1 + 1;
    if (eh2) n_eh2 <= n_eh2 + 1;
    if (ev2) n_ev2 <= n_ev2 + 1;
    if (de1) n_de1 <= n_de1 + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Frame 2 line 5 has a stretched hsync; vsync is missing for 20 lines from frame 5
  task automatic drive_pix();
    int w, sxv, syv;
    logic hact, vact;
    w    = (frame == 2 && vc == 5) ? HS + 1 : HS;
    hact = (hc >= HF) && (hc < HF + w);
    vact = (vc >= VF) && (vc < VF + VS) && !(frame == 5 || (frame == 6 && vc < 5));
    hs_p = ~hact; vs_p = ~vact; hs_q = hact; vs_q = vact;
    if (hc >= HOFS && vc >= VOFS) begin
      sxv = hc - HOFS; syv = vc - VOFS;
      vr = 4'(sxv ^ 15); vg = 4'(syv); vb = 4'(sxv + syv);
    end else begin
      vr = 4'hA; vg = 4'hA; vb = 4'hA;
    end
  endtask

  task automatic tick();
    drive_pix();
    @(posedge clk); #1;
    pos2 = pos1;
    pos1 = frame * FT + vc * HT + hc;
    if (hc == HT - 1) begin
      hc = 0;
      if (vc == VT - 1) begin vc = 0; frame++; end else vc++;
    end else hc++;
  endtask

  // Outputs visible after return belong to source pixel (f, v, h)
  task automatic run_until(input int f, input int v, input int h);
    int target, budget;
    target = f * FT + v * HT + h;
    budget = 0;
    while (pos2 != target && budget < 6000) begin tick(); budget++; end
    if (pos2 != target) begin
      chk("wait_timeout", pos2, target);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $fatal(1, "position not reached");
    end
  endtask

  initial begin
    hs_p = 1'b1; vs_p = 1'b1; hs_q = 1'b0; vs_q = 1'b0; vr = '0; vg = '0; vb = '0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_locked", int'(locked1), 0);
    chk("rst_sx", int'(sx1), 0);
    chk("rst_de", int'(de1), 0);
    chk("rst_locked_hi", int'(locked2), 0);
    rst = 1'b0;

    // clean frames: lock on the second vertical clear
    run_until(1, 2, 1);
    chk("prelock", int'(locked1), 0);
    chk("prelock_hi", int'(locked2), 0);
    run_until(1, 2, 2);
    chk("lock", int'(locked1), 1);
    chk("lock_hi", int'(locked2), 1);

    run_until(1, 7, 0);
    chk("wrap_sx", int'($signed(sx1)), 16);
    chk("wrap_sy", int'($signed(sy1)), -1);
    chk("wrap_de", int'(de1), 0);
    run_until(1, 7, 9);
    chk("org_frame", int'(frame1), 1);
    chk("org_line", int'(line1), 1);
    chk("org_sx", int'($signed(sx1)), 0);
    chk("org_sy", int'($signed(sy1)), 0);
    chk("org_de", int'(de1), 1);
    chk("org_r", int'(r1), 15);
    chk("org_g", int'(g1), 0);
    chk("org_b", int'(b1), 0);
    chk("org_frame_hi", int'(frame2), 1);
    run_until(1, 8, 5);
    chk("blank_sx", int'($signed(sx1)), -4);
    chk("blank_sy", int'($signed(sy1)), 1);
    chk("blank_de", int'(de1), 0);
    chk("blank_r", int'(r1), 0);
    run_until(1, 8, 9);
    chk("line_pulse", int'(line1), 1);
    chk("line_noframe", int'(frame1), 0);
    chk("line_g", int'(g1), 1);
    run_until(1, 14, 24);
    chk("last_sx", int'($signed(sx1)), 15);
    chk("last_sy", int'($signed(sy1)), 7);
    chk("last_de", int'(de1), 1);
    chk("last_b", int'(b1), 6);
    chk("clean_eh", n_eh1 + n_eh2, 0);
    chk("clean_ev", n_ev1 + n_ev2, 0);

    // stretched hsync
    run_until(2, 6, 1);
    chk("pre_eh_lock", int'(locked1), 1);
    run_until(2, 6, 2);
    chk("eh_pulse", int'(eh1), 1);
    chk("eh_no_ev", int'(ev1), 0);
    chk("eh_unlock", int'(locked1), 0);
    chk("eh_pulse_hi", int'(eh2), 1);
    run_until(2, 6, 3);
    chk("eh_one_cycle", int'(eh1), 0);
    run_until(4, 2, 1);
    chk("relock_pre", int'(locked1), 0);
    run_until(4, 2, 2);
    chk("relock", int'(locked1), 1);
    chk("relock_hi", int'(locked2), 1);
    chk("eh_count", n_eh1, 1);

    // missing vsync: single timeout, no data enable until relock
    run_until(5, 2, 2);
    chk("ev_pulse", int'(ev1), 1);
    chk("ev_unlock", int'(locked1), 0);
    chk("ev_pulse_hi", int'(ev2), 1);
    de_mark = n_de1;
    run_until(6, 14, 24);
    chk("ev_count", n_ev1, 1);
    chk("ev_no_de", n_de1 - de_mark, 0);
    run_until(8, 2, 1);
    chk("relock2_pre", int'(locked1), 0);
    run_until(8, 2, 2);
    chk("relock2", int'(locked1), 1);
    chk("relock2_hi", int'(locked2), 1);

    // mid-frame reset
    run_until(9, 4, 12);
    rst = 1'b1;
    tick();
    chk("mrst_sx", int'(sx1), 0);
    chk("mrst_sy", int'(sy1), 0);
    chk("mrst_de", int'(de1), 0);
    chk("mrst_rgb", int'({r1, g1, b1}), 0);
    chk("mrst_strobes", int'({line1, frame1, eh1, ev1}), 0);
    chk("mrst_locked", int'(locked1), 0);
    chk("mrst_hi", int'({locked2, de2, sx2}), 0);
    rst = 1'b0;
    run_until(11, 2, 1);
    chk("relock3_pre", int'(locked1), 0);
    run_until(11, 2, 2);
    chk("relock3", int'(locked1), 1);
    chk("relock3_hi", int'(locked2), 1);
    run_until(11, 7, 9);
    chk("relock3_frame", int'(frame1), 1);
    chk("relock3_r", int'(r1), 15);
    chk("relock3_frame_hi", int'(frame2), 1);

    chk("final_eh", n_eh1, 1);
    chk("final_ev", n_ev1, 1);
    chk("final_eh_hi", n_eh2, 1);
    chk("final_ev_hi", n_ev2, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
